// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the byte-stream instruction loader.
package instruction_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Little-endian byte-to-word shift register: the first byte of a word lands in bits [7:0].
module word_assembler
  import instruction_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_complete
);

  logic [1:0] byte_idx;

  // Shifting right means the byte taken in first ends up lowest once four have arrived.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (byte_en) begin
      word     <= {byte_data, word[WORD_W-1:8]};
      byte_idx <= byte_idx + 2'd1;
    end
  end

  assign word_complete = byte_en && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory from address 0,
// holding the core while the load is in progress.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             ByteValid,
  input  logic [7:0]       ByteData,
  output logic             ByteReady,
  output logic             MemWriteEnable,
  output logic [31:0]      MemAddress,
  output logic [31:0]      MemWriteData,
  output logic             CpuHold,
  output logic             Done,
  output logic             Error,
  output logic [CNT_W-1:0] WordsWritten,
  output state_t           debug_state
);

  // Handshake: a byte moves on a rising edge where ByteValid && ByteReady; ByteReady depends
  // only on registered state, so there is no combinational path from ByteValid to ByteReady.
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t             state, state_nxt;
  logic [7:0]         len_lo;
  logic [CNT_W-1:0]   n_words;
  logic [CNT_W-1:0]   words_written;
  logic [CNT_W-1:0]   words_inc;
  logic [15:0]        len_full;
  logic               accept;
  logic               start_ok;
  logic               load_start;
  logic [WORD_W-1:0]  word;
  logic               word_complete;

  assign accept     = ByteValid && ByteReady;
  assign start_ok   = (state == IDLE) || (state == DONE) || (state == ERROR);
  assign load_start = Start && start_ok;
  assign len_full   = {ByteData, len_lo};
  assign words_inc  = words_written + 1'b1;

  word_assembler u_word_assembler (
    .clk           (clk),
    .reset         (reset),
    .clear         (load_start),
    .byte_en       (accept && (state == DATA)),
    .byte_data     (ByteData),
    .word          (word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      len_lo        <= '0;
      n_words       <= '0;
      words_written <= '0;
    end else begin
      state <= state_nxt;
      if (load_start)
        words_written <= '0;
      if (state == LEN_LO && accept)
        len_lo <= ByteData;
      if (state == LEN_HI && accept)
        n_words <= len_full[CNT_W-1:0];
      if (state == WRITE)
        words_written <= words_inc;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (Start) state_nxt = LEN_LO;
      LEN_LO:            if (accept) state_nxt = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (len_full == 16'd0)                state_nxt = DONE;
          else if ({1'b0, len_full} > DEPTH_L)  state_nxt = ERROR;
          else                                  state_nxt = DATA;
        end
      end
      DATA:              if (word_complete) state_nxt = WRITE;
      WRITE:             state_nxt = (words_inc == n_words) ? DONE : DATA;
      default:           state_nxt = IDLE;
    endcase
  end

  assign ByteReady      = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign MemWriteEnable = (state == WRITE);
  assign MemAddress     = 32'({words_written, 2'b00});
  assign MemWriteData   = word;
  assign CpuHold        = !((state == IDLE) || (state == DONE));
  assign Done           = (state == DONE);
  assign Error          = (state == ERROR);
  assign WordsWritten   = words_written;
  assign debug_state    = state;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed and randomized loads of instruction_loader checked against a stream-level model.
module tb_instruction_loader;
  import instruction_loader_pkg::*;

  localparam int DEPTH = 256;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             Start;
  logic             ByteValid;
  logic [7:0]       ByteData;
  logic             ByteReady;
  logic             MemWriteEnable;
  logic [31:0]      MemAddress;
  logic [31:0]      MemWriteData;
  logic             CpuHold;
  logic             Done;
  logic             Error;
  logic [CNT_W-1:0] WordsWritten;
  state_t           dbg_state;

  int checks = 0;
  int errors = 0;
  int ready_during_write = 0;

  logic [7:0]  stream_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_addr_q[$];
  logic [31:0] obs_data_q[$];
  int          exp_n;
  bit          exp_err;

  instruction_loader #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .Start          (Start),
    .ByteValid      (ByteValid),
    .ByteData       (ByteData),
    .ByteReady      (ByteReady),
    .MemWriteEnable (MemWriteEnable),
    .MemAddress     (MemAddress),
    .MemWriteData   (MemWriteData),
    .CpuHold        (CpuHold),
    .Done           (Done),
    .Error          (Error),
    .WordsWritten   (WordsWritten),
    .debug_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write monitor
  always @(negedge clk) begin
    if (MemWriteEnable === 1'b1) begin
      obs_addr_q.push_back(MemAddress);
      obs_data_q.push_back(MemWriteData);
      if (ByteReady !== 1'b0) ready_during_write++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteData = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_ready"}, 32'(ByteReady), 32'd0);
    check({pfx, "_we"},    32'(MemWriteEnable), 32'd0);
    check({pfx, "_addr"},  MemAddress, 32'd0);
    check({pfx, "_data"},  MemWriteData, 32'd0);
    check({pfx, "_hold"},  32'(CpuHold), 32'd0);
    check({pfx, "_done"},  32'(Done), 32'd0);
    check({pfx, "_err"},   32'(Error), 32'd0);
    check({pfx, "_words"}, 32'(WordsWritten), 32'd0);
  endtask

  // reference model: parse the byte stream into the memory writes it should produce
  task automatic build_expected();
    exp_q.delete();
    exp_n   = int'({stream_q[1], stream_q[0]});
    exp_err = (exp_n > DEPTH);
    if (!exp_err)
      for (int i = 0; i < exp_n; i++)
        exp_q.push_back({stream_q[5+4*i], stream_q[4+4*i], stream_q[3+4*i], stream_q[2+4*i]});
  endtask

  task automatic gen_stream(input int n);
    stream_q.delete();
    stream_q.push_back(8'(n));
    stream_q.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) stream_q.push_back(8'($urandom));
  endtask

  task automatic start_load();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_ready", 32'(ByteReady), 32'd1);
    check("start_hold",  32'(CpuHold), 32'd1);
    check("start_done",  32'(Done), 32'd0);
    check("start_err",   32'(Error), 32'd0);
    check("start_words", 32'(WordsWritten), 32'd0);
  endtask

  // driver: mode 0 full rate, 1 valid every other cycle, 2 random valid
  task automatic send_bytes(input int mode, input bit noise);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < stream_q.size()) begin
      if (cyc > 400 + 8 * stream_q.size()) begin
        check("byte_timeout", 32'(idx), 32'(stream_q.size()));
        break;
      end
      case (mode)
        0:       ByteValid = 1'b1;
        1:       ByteValid = (cyc % 2 == 0);
        default: ByteValid = ($urandom_range(0, 2) != 0);
      endcase
      ByteData = ByteValid ? stream_q[idx] : 8'($urandom);
      Start = (noise && idx != stream_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      acc = ByteValid && ByteReady;
      tick();
      cyc++;
      if (acc) idx++;
    end
    ByteValid = 1'b0;
    Start = 1'b0;
  endtask

  task automatic run_load(input string tag, input int mode, input bit noise);
    build_expected();
    obs_addr_q.delete();
    obs_data_q.delete();
    start_load();
    send_bytes(mode, noise);
    if (exp_err) begin
      check({tag, "_error"}, 32'(Error), 32'd1);
      check({tag, "_eready"}, 32'(ByteReady), 32'd0);
      check({tag, "_ehold"}, 32'(CpuHold), 32'd1);
      check({tag, "_edone"}, 32'(Done), 32'd0);
    end else if (exp_n == 0) begin
      check({tag, "_done0"}, 32'(Done), 32'd1);
      check({tag, "_hold0"}, 32'(CpuHold), 32'd0);
    end else begin
      check({tag, "_lastwe"}, 32'(MemWriteEnable), 32'd1);
      tick();
      check({tag, "_done"}, 32'(Done), 32'd1);
      check({tag, "_hold"}, 32'(CpuHold), 32'd0);
    end
    check({tag, "_words"}, 32'(WordsWritten), exp_err ? 32'd0 : 32'(exp_n));
    check({tag, "_nwrites"}, 32'(obs_data_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_data_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), obs_addr_q[i], 32'(4 * i));
      check($sformatf("%s_data%0d", tag, i), obs_data_q[i], exp_q[i]);
    end
    check({tag, "_rdy_in_write"}, 32'(ready_during_write), 32'd0);
  endtask

  task automatic load_two_word_stream();
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00};
  endtask

  initial begin
    do_reset();
    check_reset_values("rst");

    // two-word program at full rate
    load_two_word_stream();
    run_load("two_word", 0, 1'b0);
    check("two_word_w0", obs_data_q[0], 32'h00100013);
    check("two_word_w1", obs_data_q[1], 32'h002081B3);
    check("two_word_a1", obs_addr_q[1], 32'h00000004);

    // zero-length header
    stream_q = '{8'h00, 8'h00};
    run_load("zero_len", 0, 1'b0);

    // oversize header: N = 257
    stream_q = '{8'h01, 8'h01};
    run_load("oversize", 0, 1'b0);
    ByteValid = 1'b1;
    ByteData  = 8'hAA;
    repeat (5) tick();
    ByteValid = 1'b0;
    check("oversize_stuck_ready", 32'(ByteReady), 32'd0);
    check("oversize_stuck_err", 32'(Error), 32'd1);
    check("oversize_no_writes", 32'(obs_data_q.size()), 32'd0);

    // same program with ByteValid toggling
    load_two_word_stream();
    run_load("toggle", 1, 1'b0);

    // reset after two data bytes of word 0
    obs_data_q.delete();
    obs_addr_q.delete();
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h00};
    start_load();
    send_bytes(0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("midword_rst");
    check("midword_no_write", 32'(obs_data_q.size()), 32'd0);
    load_two_word_stream();
    run_load("reload", 0, 1'b0);

    // restart after Done with a single word
    stream_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("deadbeef", 0, 1'b0);
    check("deadbeef_val", obs_data_q[0], 32'hDEADBEEF);

    // randomized loads with Start noise during the transfer
    for (int t = 0; t < 6; t++) begin
      gen_stream($urandom_range(1, 6));
      run_load($sformatf("rand%0d", t), $urandom_range(0, 2), 1'b1);
    end

    // largest accepted program
    gen_stream(DEPTH);
    run_load("full_depth", 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Byte-stream program loader that writes 32-bit instructions into the instruction memory's write port while holding the core idle. It sits between a serial/byte source (UART receiver, debug bridge) and the instruction memory. It turns a length-prefixed little-endian byte stream into word-aligned memory writes starting at address 0. It replaces file-based initialisation for hardware runs.

## Interface
- DEPTH, 256, instruction memory size in 32-bit words; maximum accepted word count.
- CNT_W, $clog2(DEPTH+1), width of word counters.

- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- Start  in  1  begin a load; sampled only in IDLE, DONE, ERROR.
- ByteValid  in  1  source has a byte on ByteData.
- ByteData  in  8  stream byte.
- ByteReady  out  1  loader accepts ByteData this cycle.
- MemWriteEnable  out  1  one-cycle write strobe to instruction memory.
- MemAddress  out  32  byte address of write, always 4-aligned.
- MemWriteData  out  32  assembled instruction word.
- CpuHold  out  1  keep core in reset/stall while loading.
- Done  out  1  load completed successfully; sticky until Start or reset.
- Error  out  1  header word count > DEPTH; sticky until Start or reset.
- WordsWritten  out  CNT_W  words committed in current load.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 bytes, each word little-endian (first byte → bits [7:0]).
- Byte transfer occurs on a rising edge where ByteValid && ByteReady; ByteData is not required to be stable otherwise.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + Start → LEN_LO; clears Done, Error, WordsWritten, address, byte index.
- LEN_LO: accept byte → LEN_HI. LEN_HI: accept byte → evaluate N: N==0 → DONE; N>DEPTH → ERROR; else → DATA.
- DATA: accept bytes into shift register, byte index 0..3; on 4th byte → WRITE.
- WRITE: MemWriteEnable=1, MemAddress=4×WordsWritten, MemWriteData=assembled word; ByteReady=0. Next edge: WordsWritten+1; if WordsWritten+1==N → DONE, else → DATA with byte index 0.
- ERROR: remaining stream bytes are not consumed (ByteReady=0); upstream must flush.
- CpuHold=1 in LEN_LO, LEN_HI, DATA, WRITE, ERROR; 0 in IDLE, DONE.
- Start while in LEN_LO..WRITE is ignored.
- Address arithmetic: MemAddress = {WordsWritten, 2'b00} zero-extended to 32 bits; never wraps since N ≤ DEPTH.

## Timing
- Reset values: ByteReady=0, MemWriteEnable=0, MemAddress=0, MemWriteData=0, CpuHold=0, Done=0, Error=0, WordsWritten=0, state IDLE.
- All outputs registered or decoded from registered state; no combinational path ByteValid → ByteReady.
- ByteReady=1 exactly in LEN_LO, LEN_HI, DATA.
- Per word: 4 accepted bytes + 1 WRITE cycle; minimum 5 cycles/word at full ByteValid.
- Start → ByteReady high: 1 cycle.
- Last WRITE edge → Done=1 and CpuHold=0 in the following cycle.
- Reset mid-word: partial word discarded, no write issued, CpuHold drops next cycle; memory contents already written are left as is.

## Structure
- Package instruction_loader_pkg: state enum (IDLE..ERROR), BYTES_PER_WORD=4, LEN_BYTES=2.
- One sub-module natural: word_assembler (byte shift register + 2-bit index, outputs word and word_complete); FSM, counters and memory interface stay in top.

## Test plan
- Start, stream 02 00 13 00 10 00 B3 81 20 00 at ByteValid=1 → writes 0x00100013 @0x0, 0x002081B3 @0x4; Done=1, WordsWritten=2, CpuHold=0.
- Header 00 00 → DONE two accepted bytes after Start, no MemWriteEnable pulse.
- Header 01 01 (N=257) with DEPTH=256 → Error=1, ByteReady=0, CpuHold=1, no writes.
- Same 2-word stream with ByteValid toggling every other cycle → identical writes/addresses, no byte lost or duplicated.
- reset asserted after 2 data bytes of word 0 → next cycle all outputs at reset values, no write; fresh Start reloads correctly.
- After Done, Start and 1-word stream EF BE AD DE → Done cleared, single write 0xDEADBEEF @0x0, Done=1, WordsWritten=1.
